as_mac_alu: RTL and testbench

//  Parametrised, multi-cycle successor datapath ALU for the AS embedded processor: signed add,

---
 rtl/as_alu_pkg.sv | 44 ++++
 rtl/as_mac_alu_mult.sv | 45 ++++
 rtl/as_mac_alu.sv | 166 ++++++++++++++++
 tb/tb_as_mac_alu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/as_alu_pkg.sv
// Shared types and the range-check helper for the AS multi-cycle MAC ALU.
package as_alu_pkg;

    localparam int unsigned MAX_N = 32;
    localparam int unsigned WIDE  = 2 * MAX_N + 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_MAC = 2'b10,
        OP_IN  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic             ovf;
        logic [MAX_N-1:0] val;
    } sat_res_t;

    // Range-check a full-precision value against n-bit two's complement; clamp or wrap.
    function automatic sat_res_t sat_n(input logic signed [WIDE-1:0] x,
                                       input int unsigned n,
                                       input bit sat);
        logic signed [WIDE-1:0] hi;
        logic signed [WIDE-1:0] lo;
        sat_res_t r;
        hi    = (WIDE'(1) <<< (n - 1)) - WIDE'(1);
        lo    = -hi - WIDE'(1);
        r.ovf = (x > hi) || (x < lo);
        if (sat && (x > hi))
            r.val = hi[MAX_N-1:0];
        else if (sat && (x < lo))
            r.val = lo[MAX_N-1:0];
        else
            r.val = x[MAX_N-1:0];
        return r;
    endfunction

endpackage

// File: rtl/as_mac_alu_mult.sv
// Sequential unsigned shift-add multiplier; the first partial product is taken on load,
// so the finished product is registered N cycles later with last=1.
module as_seq_mult #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic           load,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] prod,
    output logic           last
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = $clog2(N + 1);

    logic [PW-1:0] mcand;
    logic [N-1:0]  mplier;
    logic [CW-1:0] cnt;

    // cnt counts completed iterations; it parks at N when idle
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= CW'(N);
        end else if (load) begin
            prod   <= b[0] ? PW'(a) : '0;
            mcand  <= PW'(a) << 1;
            mplier <= b >> 1;
            cnt    <= CW'(1);
        end else if (cnt != CW'(N)) begin
            if (mplier[0])
                prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CW'(N));

endmodule

// File: rtl/as_mac_alu.sv
// AS datapath ALU: signed add, fixed-point multiply, multiply-accumulate and switch input,
// with start/busy/done handshake, accumulator and registered Z/N/V flags.
module as_mac_alu
    import as_alu_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned FRAC = 7,
    parameter bit          SAT  = 1'b1
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] rd_data,
    input  logic [N-1:0] rs_data,
    input  logic [N-1:0] immediate,
    input  logic [N-1:0] switches,
    input  logic         acc_clr,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] w_data,
    output logic [N-1:0] acc_out,
    output logic         z,
    output logic         n,
    output logic         v
);

    localparam int unsigned PW = 2 * N;

    state_t  state;
    state_t  state_next;
    alu_op_t op_q;
    logic    neg_q;

    logic          load_c;
    logic [N-1:0]  a_mag_c;
    logic [N-1:0]  b_mag_c;
    logic [PW-1:0] prod;
    logic          last;

    logic                 wr_c;
    logic                 acc_wr_c;
    logic [N-1:0]         res_c;
    logic                 ovf_c;
    logic signed [PW:0]   full_c;
    logic signed [PW:0]   shifted_c;
    sat_res_t             prod_sat_c;
    sat_res_t             sum_sat_c;
    sat_res_t             add_sat_c;
    logic                 sat_unused;

    // |-2^(N-1)| still fits in N unsigned bits
    assign a_mag_c = rs_data[N-1]   ? -rs_data   : rs_data;
    assign b_mag_c = immediate[N-1] ? -immediate : immediate;

    as_seq_mult #(.N(N)) u_mult (
        .clk     (clk),
        .n_reset (n_reset),
        .load    (load_c),
        .a       (a_mag_c),
        .b       (b_mag_c),
        .prod    (prod),
        .last    (last)
    );

    // Signed product, floor-shifted, then range-checked; MAC adds the checked product to acc.
    always_comb begin
        full_c     = neg_q ? -$signed({1'b0, prod}) : $signed({1'b0, prod});
        shifted_c  = full_c >>> FRAC;
        prod_sat_c = sat_n(WIDE'(shifted_c), N, SAT);
        sum_sat_c  = sat_n(WIDE'($signed(acc_out)) + WIDE'($signed(prod_sat_c.val[N-1:0])), N, SAT);
        add_sat_c  = sat_n(WIDE'($signed(rd_data)) + WIDE'($signed(immediate)), N, SAT);
    end

    assign sat_unused = ^{prod_sat_c.val, sum_sat_c.val, add_sat_c.val};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next state and result selection; DONE accepts a new start like IDLE
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        wr_c       = 1'b0;
        acc_wr_c   = 1'b0;
        res_c      = '0;
        ovf_c      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_next = S_IDLE;
                if (start) begin
                    case (alu_op_t'(op))
                        OP_ADD: begin
                            state_next = S_DONE;
                            wr_c       = 1'b1;
                            acc_wr_c   = 1'b1;
                            res_c      = add_sat_c.val[N-1:0];
                            ovf_c      = add_sat_c.ovf;
                        end
                        OP_IN: begin
                            state_next = S_DONE;
                            wr_c       = 1'b1;
                            res_c      = switches;
                        end
                        OP_MUL, OP_MAC: begin
                            state_next = S_MUL;
                            load_c     = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (last) begin
                    state_next = S_DONE;
                    wr_c       = 1'b1;
                    if (op_q == OP_MAC) begin
                        acc_wr_c = 1'b1;
                        res_c    = sum_sat_c.val[N-1:0];
                        ovf_c    = prod_sat_c.ovf | sum_sat_c.ovf;
                    end else begin
                        res_c    = prod_sat_c.val[N-1:0];
                        ovf_c    = prod_sat_c.ovf;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Latched operation, handshake, writeback, flags and accumulator
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            op_q    <= OP_ADD;
            neg_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            w_data  <= '0;
            acc_out <= '0;
            z       <= 1'b0;
            n       <= 1'b0;
            v       <= 1'b0;
        end else begin
            if (load_c) begin
                op_q  <= alu_op_t'(op);
                neg_q <= rs_data[N-1] ^ immediate[N-1];
            end
            busy <= (state_next == S_MUL);
            done <= (state_next == S_DONE);
            if (wr_c) begin
                w_data <= res_c;
                z      <= (res_c == '0);
                n      <= res_c[N-1];
                v      <= ovf_c;
            end
            if (acc_clr)
                acc_out <= '0;
            else if (acc_wr_c)
                acc_out <= res_c;
        end
    end

endmodule

// File: tb/tb_as_mac_alu.sv
// Scoreboard bench for as_mac_alu: a saturating and a wrapping instance share one stimulus stream.
module tb_as_mac_alu;

    localparam int LM = 9;
    localparam int LA = 1;

    logic       clk;
    logic       n_reset;
    logic       start;
    logic [1:0] op;
    logic [7:0] rd_data, rs_data, immediate, switches;
    logic       acc_clr;

    logic       busy, done, z, n, v;
    logic [7:0] w_data, acc_out;
    logic       busy_w, done_w, z_w, n_w, v_w;
    logic [7:0] w_data_w, acc_out_w;

    typedef struct {
        logic [7:0] w, ww, acc, accw;
        logic       ez, en, ev;
        int         due;
        int         id;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   n_issued = 0;

    as_mac_alu #(.N(8), .FRAC(7), .SAT(1'b1)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .op(op),
        .rd_data(rd_data), .rs_data(rs_data), .immediate(immediate), .switches(switches),
        .acc_clr(acc_clr), .busy(busy), .done(done), .w_data(w_data), .acc_out(acc_out),
        .z(z), .n(n), .v(v)
    );

    as_mac_alu #(.N(8), .FRAC(7), .SAT(1'b0)) dut_w (
        .clk(clk), .n_reset(n_reset), .start(start), .op(op),
        .rd_data(rd_data), .rs_data(rs_data), .immediate(immediate), .switches(switches),
        .acc_clr(acc_clr), .busy(busy_w), .done(done_w), .w_data(w_data_w), .acc_out(acc_out_w),
        .z(z_w), .n(n_w), .v(v_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [7:0] a_rd, a_rs, a_imm, a_sw,
                         input int lat, input logic [7:0] ew, eww, eacc, eaccw,
                         input logic ez, en, ev);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o;
        rd_data = a_rd; rs_data = a_rs; immediate = a_imm; switches = a_sw;
        e.w = ew; e.ww = eww; e.acc = eacc; e.accw = eaccw;
        e.ez = ez; e.en = en; e.ev = ev;
        e.due = cyc + lat;
        e.id = n_issued;
        n_issued++;
        q.push_back(e);
    endtask

    // Drop start and scramble operands so later cycles cannot depend on them
    task automatic release_ops();
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom);
        rd_data = 8'($urandom); rs_data = 8'($urandom);
        immediate = 8'($urandom); switches = 8'($urandom);
    endtask

    task automatic wait_q();
        int k = 0;
        while (q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", 32'(q.size()), 32'(0));
            q.delete();
        end
    endtask

    task automatic clear_acc();
        @(negedge clk) acc_clr = 1'b1;
        @(negedge clk) acc_clr = 1'b0;
        chk("acc_clr_sat", 32'(acc_out), 32'(0));
        chk("acc_clr_wrap", 32'(acc_out_w), 32'(0));
    endtask

    // Monitor: every done pulse pops one expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (n_reset && (done || done_w)) begin
                chk("done_pair", 32'(done_w), 32'(done));
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk($sformatf("latency[%0d]", e.id), 32'(cyc), 32'(e.due));
                    chk($sformatf("w_data[%0d]", e.id), 32'(w_data), 32'(e.w));
                    chk($sformatf("z[%0d]", e.id), 32'(z), 32'(e.ez));
                    chk($sformatf("n[%0d]", e.id), 32'(n), 32'(e.en));
                    chk($sformatf("v[%0d]", e.id), 32'(v), 32'(e.ev));
                    chk($sformatf("acc_out[%0d]", e.id), 32'(acc_out), 32'(e.acc));
                    chk($sformatf("w_data_wrap[%0d]", e.id), 32'(w_data_w), 32'(e.ww));
                    chk($sformatf("v_wrap[%0d]", e.id), 32'(v_w), 32'(e.ev));
                    chk($sformatf("acc_out_wrap[%0d]", e.id), 32'(acc_out_w), 32'(e.accw));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        n_reset = 1'b0; start = 1'b0; op = 2'b00; acc_clr = 1'b0;
        rd_data = '0; rs_data = '0; immediate = '0; switches = '0;
        repeat (2) @(negedge clk);
        chk("rst_w_data", 32'(w_data), 32'(0));
        chk("rst_acc_out", 32'(acc_out), 32'(0));
        chk("rst_flags", 32'({z, n, v}), 32'(0));
        chk("rst_busy_done", 32'({busy, done}), 32'(0));
        n_reset = 1'b1;

        // Fixed-point multiply
        issue(2'b01, 8'h00, 8'h40, 8'h40, 8'h00, LM, 8'h20, 8'h20, 8'h00, 8'h00, 0, 0, 0);
        release_ops(); wait_q();
        issue(2'b01, 8'h00, 8'hC0, 8'h40, 8'h00, LM, 8'hE0, 8'hE0, 8'h00, 8'h00, 0, 1, 0);
        release_ops(); wait_q();

        // Overflow: -1*-1 and 100+100
        issue(2'b01, 8'h00, 8'h80, 8'h80, 8'h00, LM, 8'h7F, 8'h80, 8'h00, 8'h00, 0, 0, 1);
        release_ops(); wait_q();
        issue(2'b00, 8'h64, 8'h00, 8'h64, 8'h00, LA, 8'h7F, 8'hC8, 8'h7F, 8'hC8, 0, 0, 1);
        release_ops(); wait_q();

        // Reset in the middle of a MUL: no result may appear afterwards
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_data = 8'h40; immediate = 8'h40;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        @(negedge clk) n_reset = 1'b0;
        @(negedge clk);
        chk("abort_w_data", 32'(w_data), 32'(0));
        chk("abort_acc_out", 32'(acc_out), 32'(0));
        chk("abort_flags", 32'({z, n, v}), 32'(0));
        chk("abort_busy_done", 32'({busy, done}), 32'(0));
        chk("abort_wrap", 32'({w_data_w, acc_out_w, busy_w}), 32'(0));
        n_reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_idle", 32'({busy, done}), 32'(0));

        // Accumulator clear
        issue(2'b00, 8'h10, 8'h00, 8'h20, 8'h00, LA, 8'h30, 8'h30, 8'h30, 8'h30, 0, 0, 0);
        release_ops(); wait_q();
        clear_acc();

        // MAC accumulation; clear coinciding with the third done cycle
        issue(2'b10, 8'h00, 8'h40, 8'h40, 8'h00, LM, 8'h20, 8'h20, 8'h20, 8'h20, 0, 0, 0);
        release_ops(); wait_q();
        issue(2'b10, 8'h00, 8'h40, 8'h40, 8'h00, LM, 8'h40, 8'h40, 8'h40, 8'h40, 0, 0, 0);
        release_ops(); wait_q();
        issue(2'b10, 8'h00, 8'h40, 8'h40, 8'h00, LM, 8'h60, 8'h60, 8'h60, 8'h60, 0, 0, 0);
        release_ops();
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mac3_done_seen", 32'(done), 32'(1));
        acc_clr = 1'b1;
        @(negedge clk) acc_clr = 1'b0;
        chk("clr_in_done_acc", 32'(acc_out), 32'(0));
        chk("clr_in_done_w", 32'(w_data), 32'(8'h60));
        chk("clr_in_done_acc_wrap", 32'(acc_out_w), 32'(0));
        wait_q();

        // Rebuild to 0x60, then overflow the accumulator
        issue(2'b10, 8'h00, 8'h40, 8'h40, 8'h00, LM, 8'h20, 8'h20, 8'h20, 8'h20, 0, 0, 0);
        release_ops(); wait_q();
        issue(2'b10, 8'h00, 8'h40, 8'h40, 8'h00, LM, 8'h40, 8'h40, 8'h40, 8'h40, 0, 0, 0);
        release_ops(); wait_q();
        issue(2'b10, 8'h00, 8'h40, 8'h40, 8'h00, LM, 8'h60, 8'h60, 8'h60, 8'h60, 0, 0, 0);
        release_ops(); wait_q();
        issue(2'b10, 8'h00, 8'h7F, 8'h7F, 8'h00, LM, 8'h7F, 8'hDE, 8'h7F, 8'hDE, 0, 0, 1);
        release_ops(); wait_q();

        // ADD to zero, then IN started in the ADD done cycle
        issue(2'b00, 8'h05, 8'h00, 8'hFB, 8'h00, LA, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        issue(2'b11, 8'h00, 8'h00, 8'h00, 8'hA5, LA, 8'hA5, 8'hA5, 8'h00, 8'h00, 0, 1, 0);
        release_ops(); wait_q();

        // A start pulse during MUL busy must be ignored
        issue(2'b01, 8'h00, 8'hC0, 8'h40, 8'h00, LM, 8'hE0, 8'hE0, 8'h00, 8'h00, 0, 1, 0);
        release_ops();
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b00; rd_data = 8'h01; immediate = 8'h01;
        @(negedge clk) start = 1'b0;
        wait_q();

        // Sign handling and floor rounding
        issue(2'b01, 8'h00, 8'hC0, 8'hC0, 8'h00, LM, 8'h20, 8'h20, 8'h00, 8'h00, 0, 0, 0);
        release_ops(); wait_q();
        issue(2'b01, 8'h00, 8'h01, 8'hFF, 8'h00, LM, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 1, 0);
        release_ops(); wait_q();

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
